sram_uart_fifo: RTL and testbench
=================================

Name: sram_uart_fifo

Overview:
- Next-generation memory-mapped UART front end on the 64-bit SRAM-style bus (addra/dina/douta/ena/wea).
- Replaces the single-register TX path and the one-hot shift RX buffer with parametrised circular FIFOs in both directions.
- Adds a 16550-style register subset: RBR/THR, IER, LSR with overrun detection, plus an interrupt output.
- Sits between the CPU data-memory mux and the UART PHY (tx_*/rx_* valid/ready byte streams).

Parameters:
- BASE_ADDR, 64'h60000000, base of the 8-byte register window (addra[63:3] decode is done upstream; kept for documentation).
- TX_DEPTH, 16, TX FIFO entries; power of two, >=2.
- RX_DEPTH, 16, RX FIFO entries; power of two, >=2.

Ports:
- clka  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- addra  in  64  byte address; only addra[2:0] is used (register offset).
- dina  in  64  write data; the byte for offset k is dina[8k+7:8k].
- douta  out  64  registered read data, byte lane k = register at offset k.
- ena  in  1  access strobe, one cycle per transaction.
- wea  in  8  byte write enables; wea[k] writes offset k.
- tx_data  out  8  byte to PHY.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  PHY accepts tx_data.
- rx_data  in  8  byte from PHY.
- rx_valid  in  1  PHY byte available.
- rx_ready  out  1  always 1 out of reset; overflow is flagged, not back-pressured.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - both FIFOs empty; IER=0; OE=0; douta=0; tx_valid=0; irq=0.
  - rx_ready=0 while rstn=0, 1 otherwise.
- Register map (offset = addra[2:0]; offsets 2,3,4,6,7 read 0 and ignore writes):
  - Offset 0 read = RBR: RX FIFO head, or 0 when empty.
  - Offset 0 write = THR.
  - Offset 1 = IER, R/W: bit0 RX-data interrupt enable, bit1 THR-empty interrupt enable; bits 7:2 read 0.
  - Offset 5 = LSR, read-only:
    - bit0 DR = RX FIFO non-empty.
    - bit1 OE = overrun.
    - bit5 THRE = TX FIFO empty.
    - bit6 TEMT = TX FIFO empty and tx_valid=0.
- Read timing:
  - When ena=1, douta <= {16'd0, LSR, 24'd0, IER, RBR} at the clock edge, regardless of wea; latency 1 cycle.
  - When ena=0, douta holds its value.
  - LSR and RBR are sampled before any same-cycle pop, push or OE clear.
- RX pop: ena && !wea[0] && addra[2:0]==0 with the FIFO non-empty. Pop on an empty FIFO is a no-op.
- OE clear: any ena && !wea[5] && addra[2:0]==5 (an LSR read) clears OE after sampling.
  - If an overrun occurs in the same cycle as the clear, OE ends at 1 (set wins).
- RX push: rx_valid=1 and rstn=1.
  - FIFO not full: store rx_data.
  - FIFO full and no same-cycle pop: drop the byte and set OE.
  - FIFO full with a same-cycle pop: accept, count unchanged, OE untouched.
- TX push: ena && wea[0] && addra[2:0]==0 stores dina[7:0].
  - If full with no same-cycle PHY accept, the byte is dropped silently (the CPU must poll THRE).
  - If full with a same-cycle accept, it is stored.
- TX drain:
  - tx_valid = TX non-empty; tx_data = TX head (combinational from storage).
  - A byte is retired on tx_valid && tx_ready.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
- Pointers are log2(DEPTH)+1 bits: wrap on the low bits; full when MSBs differ and the rest are equal.
- Pointer updates are registered; the count is visible in LSR the cycle after a push or pop.
- irq = (IER[0] & DR) | (IER[1] & THRE), registered (1-cycle lag).
- Simulation only: a TX push prints the character with $write.
- Reset mid-operation: all FIFO contents are discarded immediately; the PHY sees tx_valid fall asynchronously.

Decomposition:
- Package sram_uart_pkg holds:
  - register offset constants: UART_RBR_THR=0, UART_IER=1, UART_LSR=5;
  - LSR bit indices: DR=0, OE=1, THRE=5, TEMT=6;
  - IER bit indices.
- One sub-module, uart_sync_fifo (parameters DEPTH, WIDTH=8; ports push/pop/din/dout/empty/full), instantiated twice.

Test Plan:
- Reset, then read offset 5 -> douta[47:40]=8'h60, douta[7:0]=0, irq=0, rx_ready=1.
- With tx_ready=0, write 'A','B','C' to offset 0, then set tx_ready=1:
  - tx_valid stays 1 with tx_data=8'h41 while stalled;
  - PHY then sees 41,42,43 in order;
  - LSR THRE=0 until the third accept, then 8'h60.
- Push RX_DEPTH+1 bytes 0x10..0x20 with no reads:
  - LSR reads 8'h63 (DR|OE|THRE|TEMT);
  - a second LSR read gives 8'h61;
  - RBR reads return 0x10..0x1F; 0x20 is lost.
- RX full, with rx_valid and an offset-0 read in the same cycle -> no OE; the new byte is read last.
- Write IER=8'h01, push one RX byte -> irq=1 two cycles after rx_valid; read RBR -> irq=0 after the pop.
- Assert rstn low while TX holds 5 bytes and tx_ready=0 -> tx_valid=0 immediately; after release, LSR=8'h60.

Source files
------------

// File: rtl/sram_uart_pkg.sv
// Shared constants for the SRAM-bus UART front end:
// register offsets, LSR/IER bit positions and an LSR builder.
package sram_uart_pkg;

  localparam logic [2:0] UART_RBR_THR = 3'd0;
  localparam logic [2:0] UART_IER     = 3'd1;
  localparam logic [2:0] UART_LSR     = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam int IER_RDA  = 0;
  localparam int IER_THRE = 1;

  typedef struct packed {
    logic dr;
    logic oe;
    logic thre;
    logic temt;
  } lsr_t;

  function automatic logic [7:0] lsr_byte(input lsr_t s);
    logic [7:0] b;
    b           = 8'd0;
    b[LSR_DR]   = s.dr;
    b[LSR_OE]   = s.oe;
    b[LSR_THRE] = s.thre;
    b[LSR_TEMT] = s.temt;
    return b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular FIFO with an extra pointer MSB for full/empty.
// A push into a full FIFO lands only if a pop frees a slot.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  import sram_uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout_o  = mem_q[rp_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wp_d = do_push ? wp_q + (AW+1)'(1) : wp_q;
  assign rp_d = do_pop  ? rp_q + (AW+1)'(1) : rp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/sram_uart_fifo.sv
// UART register window on the 64-bit SRAM bus with TX/RX FIFOs,
// 16550-style RBR/THR, IER and LSR, and a level interrupt.
module sram_uart_fifo #(
  parameter logic [63:0] BASE_ADDR = 64'h6000_0000,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic        clka,
  input  logic        rstn,
  input  logic [63:0] addra,
  input  logic [63:0] dina,
  output logic [63:0] douta,
  input  logic        ena,
  input  logic [7:0]  wea,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);
  import sram_uart_pkg::*;

  logic [2:0]  off;
  logic        tx_push, tx_pop;
  logic        tx_empty, tx_full;
  logic        rx_pop;
  logic        rx_empty, rx_full;
  logic [7:0]  rx_head, rbr, lsr;
  logic        overrun, oe_clr;
  logic        ier_wr;
  logic [1:0]  ier_q;
  logic        oe_q;
  logic        irq_q;
  logic [63:0] douta_q;
  logic        unused_ok;

  assign off = addra[2:0];

  assign tx_push = ena && wea[0] && (off == UART_RBR_THR);
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_pop  = ena && !wea[0] && (off == UART_RBR_THR);
  assign oe_clr  = ena && !wea[5] && (off == UART_LSR);
  assign ier_wr  = ena && wea[1] && (off == UART_IER);

  // A full FIFO is never empty, so any RBR read frees a slot.
  assign overrun = rx_valid && rx_full && !rx_pop;

  assign rbr = rx_empty ? 8'd0 : rx_head;
  assign lsr = lsr_byte('{dr:   !rx_empty,
                          oe:   oe_q,
                          thre: tx_empty,
                          temt: tx_empty && !tx_valid});

  assign tx_valid = !tx_empty;
  assign rx_ready = rstn;
  assign irq      = irq_q;
  assign douta    = douta_q;

  uart_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx (
    .clk_i   (clka),
    .rst_ni  (rstn),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (dina[7:0]),
    .dout_o  (tx_data),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  uart_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx (
    .clk_i   (clka),
    .rst_ni  (rstn),
    .push_i  (rx_valid),
    .pop_i   (rx_pop),
    .din_i   (rx_data),
    .dout_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      ier_q   <= 2'd0;
      oe_q    <= 1'b0;
      irq_q   <= 1'b0;
      douta_q <= 64'd0;
    end else begin
      if (ier_wr) ier_q <= dina[9:8];
      if (overrun)     oe_q <= 1'b1;
      else if (oe_clr) oe_q <= 1'b0;
      irq_q <= (ier_q[IER_RDA]  && !rx_empty) ||
               (ier_q[IER_THRE] && tx_empty);
      if (ena) begin
        douta_q <= {16'd0, lsr, 24'd0,
                    6'd0, ier_q, rbr};
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clka) begin
    if (rstn && tx_push) $write("%c", dina[7:0]);
  end
`endif

  assign unused_ok = ^{addra[63:3], dina[63:10],
                       wea[7:6], wea[4:2], tx_full,
                       BASE_ADDR};

endmodule

// File: tb/tb_sram_uart_fifo.sv
// Bench for sram_uart_fifo: register vector table plus
// queue scoreboards for the TX and RX byte streams.
module tb_sram_uart_fifo;

  logic        clka = 1'b0;
  logic        rstn;
  logic [63:0] addra;
  logic [63:0] dina;
  logic [63:0] douta;
  logic        ena;
  logic [7:0]  wea;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  typedef struct {
    logic [2:0]  off;
    logic [63:0] wd;
    logic [7:0]  we;
    logic [63:0] exp_do;
  } vec_t;

  vec_t vt[9];

  always #5 clka = ~clka;

  sram_uart_fifo #(
    .BASE_ADDR (64'h6000_0000),
    .TX_DEPTH  (16),
    .RX_DEPTH  (16)
  ) dut (
    .clka     (clka),
    .rstn     (rstn),
    .addra    (addra),
    .dina     (dina),
    .douta    (douta),
    .ena      (ena),
    .wea      (wea),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic acc(input logic [2:0] off,
                     input logic [63:0] d,
                     input logic [7:0] we);
    @(negedge clka);
    addra = {61'h0C00_0000, off};
    dina  = d;
    wea   = we;
    ena   = 1'b1;
    @(negedge clka);
    ena   = 1'b0;
    wea   = 8'd0;
  endtask

  task automatic rd_lsr(input string nm, input logic [7:0] exp);
    acc(3'd5, 64'd0, 8'd0);
    chk(nm, {56'd0, douta[47:40]}, {56'd0, exp});
  endtask

  task automatic rd_rbr(input string nm);
    logic [7:0] e;
    acc(3'd0, 64'd0, 8'd0);
    e = (rxq.size() > 0) ? rxq.pop_front() : 8'd0;
    chk(nm, {56'd0, douta[7:0]}, {56'd0, e});
  endtask

  task automatic thr_wr(input logic [7:0] b);
    acc(3'd0, {56'd0, b}, 8'h01);
    txq.push_back(b);
  endtask

  // TX monitor: inputs change on negedge, sample 2ns later
  always begin
    @(negedge clka);
    #2;
    if (rstn && tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        chk("tx_unexpected", {56'd0, tx_data}, 64'd0);
      end else begin
        chk("tx_byte", {56'd0, tx_data},
            {56'd0, txq.pop_front()});
      end
    end
  end

  initial begin
    rstn     = 1'b0;
    addra    = 64'd0;
    dina     = 64'd0;
    ena      = 1'b0;
    wea      = 8'd0;
    tx_ready = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;

    vt[0] = '{3'd5, 64'h0,         8'h00, 64'h0000_6000_0000_0000};
    vt[1] = '{3'd1, 64'h0300,      8'h02, 64'h0000_6000_0000_0000};
    vt[2] = '{3'd2, 64'h0,         8'h00, 64'h0000_6000_0000_0300};
    vt[3] = '{3'd1, 64'hFF00,      8'h02, 64'h0000_6000_0000_0300};
    vt[4] = '{3'd3, 64'h0,         8'h00, 64'h0000_6000_0000_0300};
    vt[5] = '{3'd7, {64{1'b1}},    8'hFF, 64'h0000_6000_0000_0300};
    vt[6] = '{3'd4, 64'h0,         8'h00, 64'h0000_6000_0000_0300};
    vt[7] = '{3'd1, 64'h0,         8'h02, 64'h0000_6000_0000_0300};
    vt[8] = '{3'd6, 64'h0,         8'h00, 64'h0000_6000_0000_0000};

    repeat (2) @(negedge clka);
    chk("rst_douta",  douta, 64'd0);
    chk("rst_txv",    {63'd0, tx_valid}, 64'd0);
    chk("rst_irq",    {63'd0, irq}, 64'd0);
    chk("rst_rxrdy",  {63'd0, rx_ready}, 64'd0);
    rstn = 1'b1;
    @(negedge clka);
    chk("rxrdy_on",   {63'd0, rx_ready}, 64'd1);

    // register window vectors
    for (int i = 0; i < 9; i++) begin
      acc(vt[i].off, vt[i].wd, vt[i].we);
      chk($sformatf("vec%0d", i), douta, vt[i].exp_do);
    end
    chk("irq_idle", {63'd0, irq}, 64'd0);

    // TX stalled then drained in order
    thr_wr(8'h41);
    thr_wr(8'h42);
    thr_wr(8'h43);
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      chk("tx_stall_v", {63'd0, tx_valid}, 64'd1);
      chk("tx_stall_d", {56'd0, tx_data}, 64'h41);
    end
    rd_lsr("lsr_tx_busy", 8'h00);
    @(negedge clka);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && txq.size() > 0; i++) begin
      @(negedge clka);
    end
    chk("tx_drain_left", txq.size(), 0);
    @(negedge clka);
    tx_ready = 1'b0;
    rd_lsr("lsr_tx_done", 8'h60);

    // RX overrun: 17 bytes, last one lost
    for (int i = 0; i < 17; i++) begin
      @(negedge clka);
      rx_valid = 1'b1;
      rx_data  = 8'h10 + 8'(i);
      if (i < 16) rxq.push_back(rx_data);
    end
    @(negedge clka);
    rx_valid = 1'b0;
    rd_lsr("lsr_ovr",   8'h63);
    rd_lsr("lsr_ovr2",  8'h61);
    for (int i = 0; i < 16; i++) rd_rbr("rbr_ovr");
    rd_lsr("lsr_rx_empty", 8'h60);
    rd_rbr("rbr_empty");

    // full RX with push and pop in the same cycle
    for (int i = 0; i < 16; i++) begin
      @(negedge clka);
      rx_valid = 1'b1;
      rx_data  = 8'h30 + 8'(i);
      rxq.push_back(rx_data);
    end
    @(negedge clka);
    rx_data = 8'h40;
    rxq.push_back(8'h40);
    addra = 64'h6000_0000;
    wea   = 8'd0;
    ena   = 1'b1;
    @(negedge clka);
    ena      = 1'b0;
    rx_valid = 1'b0;
    chk("rbr_simul", {56'd0, douta[7:0]},
        {56'd0, rxq.pop_front()});
    rd_lsr("lsr_no_oe", 8'h61);
    for (int i = 0; i < 16; i++) rd_rbr("rbr_simul_q");
    rd_lsr("lsr_rx_empty2", 8'h60);

    // RX-data interrupt
    acc(3'd1, 64'h0100, 8'h02);
    @(negedge clka);
    chk("irq_ier_only", {63'd0, irq}, 64'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    rxq.push_back(8'h55);
    @(negedge clka);
    rx_valid = 1'b0;
    chk("irq_lag", {63'd0, irq}, 64'd0);
    @(negedge clka);
    chk("irq_set", {63'd0, irq}, 64'd1);
    rd_rbr("rbr_irq");
    chk("irq_hold", {63'd0, irq}, 64'd1);
    @(negedge clka);
    chk("irq_clr", {63'd0, irq}, 64'd0);
    acc(3'd1, 64'h0, 8'h02);

    // reset while TX holds bytes
    thr_wr(8'h56);
    thr_wr(8'h57);
    thr_wr(8'h58);
    thr_wr(8'h59);
    thr_wr(8'h5A);
    @(negedge clka);
    chk("tx_pre_rst", {63'd0, tx_valid}, 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("tx_async_rst", {63'd0, tx_valid}, 64'd0);
    chk("rxrdy_rst",    {63'd0, rx_ready}, 64'd0);
    txq.delete();
    rxq.delete();
    repeat (2) @(negedge clka);
    rstn = 1'b1;
    @(negedge clka);
    chk("douta_post_rst", douta, 64'd0);
    chk("irq_post_rst", {63'd0, irq}, 64'd0);
    rd_lsr("lsr_post_rst", 8'h60);
    chk("txv_post_rst", {63'd0, tx_valid}, 64'd0);

    repeat (2) @(negedge clka);
    $display("");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
